// File: rtl/comparator_bist.sv
// Stimulus generator and checker for a 1-bit magnitude comparator (eq/neq/gt/lt).
// Latency: done pulses 4*(HOLD_CYCLES+1)+1 cycles after start is sampled.
// Backpressure: none; start is only accepted in IDLE, and start while busy is dropped.
// Optional build macro STOP_ON_FAIL_EN: end the run at the first failing vector.
module comparator_bist #(
  parameter int HOLD_CYCLES = 20,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       eq_in,
  input  logic       neq_in,
  input  logic       gt_in,
  input  logic       lt_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [HOLD_W-1:0] cnt;
  logic [3:0]        smp;      // {eq, neq, gt, lt} captured at the end of DRIVE
  logic [3:0]        exp_v;
  logic              hold_done;
  logic              mismatch;

  assign hold_done = (cnt == HOLD_LAST);

  // Expected comparator response for the vector currently applied
  always_comb begin
    exp_v    = {~(idx[1] ^ idx[0]), idx[1] ^ idx[0], idx[1] & ~idx[0], ~idx[1] & idx[0]};
    mismatch = (smp != exp_v);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and stimulus/status outputs
  always_comb begin
    state_nxt = state;
    a         = 1'b0;
    b         = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        {a, b} = idx;
        if (hold_done) state_nxt = CHECK;
      end
      CHECK: begin
        {a, b} = idx;
`ifdef STOP_ON_FAIL_EN
        if (mismatch || idx == 2'd3) state_nxt = DONE;
        else                         state_nxt = DRIVE;
`else
        if (idx == 2'd3) state_nxt = DONE;
        else             state_nxt = DRIVE;
`endif
      end
      DONE: begin
        done = 1'b1;
`ifdef STOP_ON_FAIL_EN
        // Leave the failing vector on the board pins for inspection
        {a, b} = idx;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, hold counter, capture and result bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      cnt        <= '0;
      smp        <= 4'd0;
      pass       <= 1'b0;
      fail_vec   <= 4'd0;
      fail_count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= 2'd0;
            cnt        <= '0;
            pass       <= 1'b0;
            fail_vec   <= 4'd0;
            fail_count <= 3'd0;
          end
        end
        DRIVE: begin
          cnt <= cnt + 1'b1;
          if (hold_done) smp <= {eq_in, neq_in, gt_in, lt_in};
        end
        CHECK: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            fail_count    <= fail_count + 3'd1;
          end
          if (state_nxt == DRIVE) begin
            idx <= idx + 2'd1;
            cnt <= '0;
          end
          // Result must be valid while done is high, so fold in this check's outcome
          if (state_nxt == DONE) pass <= ~mismatch && (fail_vec == 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
module tb_comparator_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a, b, eq_in, neq_in, gt_in, lt_in;
  logic       busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] fail_count;

  logic       start1 = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] fail_vec1;
  logic [2:0] fail_count1;

  int mode = 0;  // 0 ideal, 1 gt stuck-at-0, 2 eq/neq swapped
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Comparator under test, with selectable faults
  always_comb begin
    eq_in  = ~(a ^ b);
    neq_in = a ^ b;
    gt_in  = a & ~b;
    lt_in  = ~a & b;
    if (mode == 1) gt_in = 1'b0;
    if (mode == 2) begin
      eq_in  = a ^ b;
      neq_in = ~(a ^ b);
    end
  end

  comparator_bist #(.HOLD_CYCLES(20), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .eq_in(eq_in), .neq_in(neq_in), .gt_in(gt_in), .lt_in(lt_in),
    .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec), .fail_count(fail_count)
  );

  comparator_bist #(.HOLD_CYCLES(1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .eq_in(~(a1 ^ b1)), .neq_in(a1 ^ b1), .gt_in(a1 & ~b1), .lt_in(~a1 & b1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fail_vec1), .fail_count(fail_count1)
  );

  // Start pulse sampled on the next rising edge (edge 0 of the run)
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Steps `limit` edges after edge 0, recording the first done cycle and results there
  task automatic wait_done(input int limit, input int poke_edge, input bit chk_seq,
                           output int done_cyc, output int pulses, output bit seq_err,
                           output logic [1:0] ab_d, output logic pass_d,
                           output logic [3:0] fv_d, output logic [2:0] fc_d);
    done_cyc = -1;
    pulses   = 0;
    seq_err  = 1'b0;
    ab_d     = 2'bxx;
    pass_d   = 1'bx;
    fv_d     = 4'bxxxx;
    fc_d     = 3'bxxx;
    for (int e = 1; e <= limit; e++) begin
      @(posedge clk);
      #1;
      start = (e == poke_edge);
      if (chk_seq && e <= 83) begin
        logic [1:0] v;
        v = 2'(e / 21);
        if ({a, b} !== v || busy !== 1'b1) seq_err = 1'b1;
      end
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = e + 1;
          ab_d     = {a, b};
          pass_d   = pass;
          fv_d     = fail_vec;
          fc_d     = fail_count;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({a, b, busy, done, pass, fail_vec, fail_count} !== 11'd0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {a, b, busy, done, pass, fail_vec, fail_count});
    end
    n_vec++;
    if ({a1, b1, busy1, done1, pass1, fail_vec1, fail_count1} !== 11'd0) begin
      n_miss++;
      $display("FAIL reset_outputs_h1: got %b expected all zero",
               {a1, b1, busy1, done1, pass1, fail_vec1, fail_count1});
    end
  endtask

  task automatic test_ideal();
    int dc, np; bit se; logic [1:0] ab; logic p; logic [3:0] fv; logic [2:0] fc;
    mode = 0;
    kick();
    wait_done(100, -1, 1'b1, dc, np, se, ab, p, fv, fc);
    n_vec++; if (dc !== 85) begin n_miss++; $display("FAIL ideal_done_cycle: got %0d expected 85", dc); end
    n_vec++; if (se !== 1'b0) begin n_miss++; $display("FAIL ideal_ab_sequence: got err=%0d expected 0", se); end
    n_vec++; if (ab !== 2'b00) begin n_miss++; $display("FAIL ideal_ab_in_done: got %b expected 00", ab); end
    n_vec++; if ({p, fv, fc} !== {1'b1, 4'b0000, 3'd0}) begin
      n_miss++; $display("FAIL ideal_result: got pass=%b fv=%b fc=%0d expected 1 0000 0", p, fv, fc);
    end
    n_vec++; if (busy !== 1'b0 || pass !== 1'b1) begin
      n_miss++; $display("FAIL ideal_idle_hold: got busy=%b pass=%b expected 0 1", busy, pass);
    end
  endtask

  task automatic test_gt_stuck();
    int dc, np; bit se; logic [1:0] ab; logic p; logic [3:0] fv; logic [2:0] fc;
    int exp_dc; logic [1:0] exp_ab;
`ifdef STOP_ON_FAIL_EN
    exp_dc = 64; exp_ab = 2'b10;
`else
    exp_dc = 85; exp_ab = 2'b00;
`endif
    mode = 1;
    kick();
    wait_done(100, -1, 1'b0, dc, np, se, ab, p, fv, fc);
    n_vec++; if (dc !== exp_dc) begin n_miss++; $display("FAIL gt_done_cycle: got %0d expected %0d", dc, exp_dc); end
    n_vec++; if (ab !== exp_ab) begin n_miss++; $display("FAIL gt_ab_in_done: got %b expected %b", ab, exp_ab); end
    n_vec++; if ({p, fv, fc} !== {1'b0, 4'b0100, 3'd1}) begin
      n_miss++; $display("FAIL gt_result: got pass=%b fv=%b fc=%0d expected 0 0100 1", p, fv, fc);
    end
    n_vec++; if ({a, b} !== 2'b00) begin n_miss++; $display("FAIL gt_ab_idle: got %b expected 00", {a, b}); end
    mode = 0;
  endtask

  task automatic test_swap();
    int dc, np; bit se; logic [1:0] ab; logic p; logic [3:0] fv; logic [2:0] fc;
    int exp_dc; logic [3:0] exp_fv; logic [2:0] exp_fc;
`ifdef STOP_ON_FAIL_EN
    exp_dc = 22; exp_fv = 4'b0001; exp_fc = 3'd1;
`else
    exp_dc = 85; exp_fv = 4'b1111; exp_fc = 3'd4;
`endif
    mode = 2;
    kick();
    wait_done(100, -1, 1'b0, dc, np, se, ab, p, fv, fc);
    n_vec++; if (dc !== exp_dc) begin n_miss++; $display("FAIL swap_done_cycle: got %0d expected %0d", dc, exp_dc); end
    n_vec++; if ({p, fv, fc} !== {1'b0, exp_fv, exp_fc}) begin
      n_miss++; $display("FAIL swap_result: got pass=%b fv=%b fc=%0d expected 0 %b %0d", p, fv, fc, exp_fv, exp_fc);
    end
    mode = 0;
  endtask

  task automatic test_restart_ignored();
    int dc, np; bit se; logic [1:0] ab; logic p; logic [3:0] fv; logic [2:0] fc;
    mode = 0;
    kick();
    wait_done(100, 29, 1'b1, dc, np, se, ab, p, fv, fc);
    n_vec++; if (dc !== 85) begin n_miss++; $display("FAIL restart_done_cycle: got %0d expected 85", dc); end
    n_vec++; if (np !== 1) begin n_miss++; $display("FAIL restart_done_pulses: got %0d expected 1", np); end
    n_vec++; if (se !== 1'b0) begin n_miss++; $display("FAIL restart_ab_sequence: got err=%0d expected 0", se); end
  endtask

  task automatic test_reset_mid_run();
    int dc, np; bit se; logic [1:0] ab; logic p; logic [3:0] fv; logic [2:0] fc;
    mode = 2;
    kick();
    repeat (39) @(posedge clk);
    #1;
    n_vec++; if ({a, b, busy, fail_vec} !== {2'b01, 1'b1, 4'b0001}) begin
      n_miss++; $display("FAIL pre_reset_state: got ab=%b busy=%b fv=%b expected 01 1 0001", {a, b}, busy, fail_vec);
    end
    rst = 1'b1;
    #1;
    n_vec++; if ({a, b, busy, fail_vec, fail_count} !== 10'd0) begin
      n_miss++; $display("FAIL async_reset: got ab=%b busy=%b fv=%b fc=%0d expected all zero",
                         {a, b}, busy, fail_vec, fail_count);
    end
    mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    kick();
    wait_done(100, -1, 1'b1, dc, np, se, ab, p, fv, fc);
    n_vec++; if (dc !== 85) begin n_miss++; $display("FAIL fresh_done_cycle: got %0d expected 85", dc); end
    n_vec++; if ({p, fv, fc} !== {1'b1, 4'b0000, 3'd0}) begin
      n_miss++; $display("FAIL fresh_result: got pass=%b fv=%b fc=%0d expected 1 0000 0", p, fv, fc);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int last = -100;
    start1 = 1'b1;
    @(posedge clk);  // edge 0: first run accepted
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == last + 2) begin
        n_vec++;
        if (pass1 !== 1'b0 || fail_vec1 !== 4'd0 || busy1 !== 1'b1) begin
          n_miss++; $display("FAIL b2b_clear_at_start: got pass=%b fv=%b busy=%b expected 0 0000 1",
                             pass1, fail_vec1, busy1);
        end
      end
      if (done1 === 1'b1) begin
        n_vec++;
        if (e !== 8 + 10 * k || pass1 !== 1'b1) begin
          n_miss++; $display("FAIL b2b_done_%0d: got edge=%0d pass=%b expected edge=%0d pass=1",
                             k, e, pass1, 8 + 10 * k);
        end
        k++;
        last = e;
      end
    end
    start1 = 1'b0;
    n_vec++; if (k !== 4) begin n_miss++; $display("FAIL b2b_done_count: got %0d expected 4", k); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_ideal();
    test_gt_stuck();
    test_swap();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
